bf_search_ctrl: RTL and testbench

//  Sequences the brute-force password search: odometer of per-position ASCII counters over 'a'..'z'.

---
 rtl/bf_search_ctrl_pkg.sv | 12 +
 rtl/bf_search_ctrl_if.sv | 31 +++
 rtl/bf_search_ctrl_odometer_add.sv | 36 +++
 rtl/bf_search_ctrl.sv | 120 ++++++++++++
 tb/tb_bf_search_ctrl.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/bf_search_ctrl_pkg.sv
// Shared types and constants for the brute-force search controller.
package bf_pkg;
  localparam logic [7:0] CHAR_BASE  = 8'h61;
  localparam int         CHAR_RANGE = 26;
  localparam int         DIGIT_W    = 5;

  typedef enum logic [1:0] {IDLE, RUN, FOUND, DONE} state_t;

  function automatic logic [7:0] dchar(input logic [DIGIT_W-1:0] d);
    return CHAR_BASE + 8'(d);
  endfunction
endpackage

// File: rtl/bf_search_ctrl_if.sv
// Host-side control/result bundle for bf_search_ctrl.
// BF_SEED_EN adds a per-digit seed so units can split the keyspace.
interface bf_search_ctrl_if import bf_pkg::*; #(
  parameter int MAX_LEN = 4,
  parameter int CNT_W   = 32
);
  logic                 start;
  logic                 abort;
  logic [MAX_LEN*8-1:0] target;
  logic [2:0]           target_len;
`ifdef BF_SEED_EN
  logic [MAX_LEN*DIGIT_W-1:0] seed;
`endif
  logic                 busy;
  logic                 found;
  logic                 exhausted;
  logic [MAX_LEN*8-1:0] found_word;
  logic [CNT_W-1:0]     attempts;

`ifdef BF_SEED_EN
  modport master (output start, abort, target, target_len, seed,
                  input  busy, found, exhausted, found_word, attempts);
  modport slave  (input  start, abort, target, target_len, seed,
                  output busy, found, exhausted, found_word, attempts);
`else
  modport master (output start, abort, target, target_len,
                  input  busy, found, exhausted, found_word, attempts);
  modport slave  (input  start, abort, target, target_len,
                  output busy, found, exhausted, found_word, attempts);
`endif
endinterface

// File: rtl/bf_search_ctrl_odometer_add.sv
// Base-26 add of a small constant across the live digits; ovf = carry out of the top live digit.
module bf_odometer_add import bf_pkg::*; #(
  parameter int MAX_LEN = 4,
  parameter int INC_W   = 4
) (
  input  logic [MAX_LEN-1:0][DIGIT_W-1:0] din,
  input  logic [2:0]                      len,
  input  logic [INC_W-1:0]                inc,
  output logic [MAX_LEN-1:0][DIGIT_W-1:0] dout,
  output logic                            ovf
);
  localparam int SW = DIGIT_W + 1;

  logic [SW-1:0]    sum;
  logic [INC_W-1:0] cy;

  // inc never exceeds 8, so after the first digit the carry is at most 1
  always_comb begin
    cy   = inc;
    sum  = '0;
    dout = din;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len)) begin
        sum = SW'(din[i]) + SW'(cy);
        if (sum >= SW'(CHAR_RANGE)) begin
          dout[i] = DIGIT_W'(sum - SW'(CHAR_RANGE));
          cy      = INC_W'(1);
        end else begin
          dout[i] = DIGIT_W'(sum);
          cy      = '0;
        end
      end
    end
    ovf = (cy != '0);
  end
endmodule

// File: rtl/bf_search_ctrl.sv
// Brute-force search sequencer: NUM_LANES consecutive candidates checked per cycle.
// BF_SEED_EN: digits load from bus.seed on start instead of zero.
module bf_search_ctrl import bf_pkg::*; #(
  parameter int MAX_LEN   = 4,
  parameter int NUM_LANES = 4,
  parameter int CNT_W     = 32
) (
  input logic             clk,
  input logic             rst_n,
  bf_search_ctrl_if.slave bus
);
  localparam int WW = MAX_LEN * 8;
  localparam int AW = CNT_W + 1;

  state_t state, state_nxt;

  logic [MAX_LEN-1:0][DIGIT_W-1:0] digits, base_nxt, seed_dig;
  logic [NUM_LANES-1:0][MAX_LEN-1:0][DIGIT_W-1:0] lane_dig;
  logic [NUM_LANES-1:0][WW-1:0] lane_word;
  logic [NUM_LANES-1:0]         lane_ovf, lane_hit;
  logic [MAX_LEN-1:0]           seed_bad;
  logic [WW-1:0]                tgt_q, tgt_m, hit_word, found_word_q;
  logic [2:0]                   len_q;
  logic [CNT_W-1:0]             attempts_q, att_nxt;
  logic [AW-1:0]                att_sum;
  logic [3:0]                   add_cnt;
  logic                         base_ovf, hit_any, all_vld, start_ok;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    bf_odometer_add #(.MAX_LEN(MAX_LEN), .INC_W(4)) u_add (
      .din(digits), .len(len_q), .inc(4'(l)), .dout(lane_dig[l]), .ovf(lane_ovf[l]));
    for (genvar c = 0; c < MAX_LEN; c++) begin : g_chr
      assign lane_word[l][c*8 +: 8] = (c < int'(len_q)) ? dchar(lane_dig[l][c]) : 8'h00;
    end
    assign lane_hit[l] = !lane_ovf[l] && (lane_word[l] == tgt_q);
  end

  bf_odometer_add #(.MAX_LEN(MAX_LEN), .INC_W(4)) u_base (
    .din(digits), .len(len_q), .inc(4'(NUM_LANES)), .dout(base_nxt), .ovf(base_ovf));

  // Dead target bytes are zeroed so they line up with the zero-padded candidates
  for (genvar c = 0; c < MAX_LEN; c++) begin : g_tgt
    assign tgt_m[c*8 +: 8] = (c < int'(bus.target_len)) ? bus.target[c*8 +: 8] : 8'h00;
`ifdef BF_SEED_EN
    assign seed_dig[c] = bus.seed[c*DIGIT_W +: DIGIT_W];
`else
    assign seed_dig[c] = '0;
`endif
    assign seed_bad[c] = (c < int'(bus.target_len)) && (seed_dig[c] >= DIGIT_W'(CHAR_RANGE));
  end

  assign start_ok = (bus.target_len != 3'd0) && (int'(bus.target_len) <= MAX_LEN) && !(|seed_bad);
  assign all_vld  = ~|lane_ovf;

  // Lowest matching lane wins; otherwise count every lane that stayed in range
  always_comb begin
    hit_any  = 1'b0;
    hit_word = '0;
    add_cnt  = '0;
    for (int l = NUM_LANES - 1; l >= 0; l--) begin
      if (lane_hit[l]) begin
        hit_any  = 1'b1;
        hit_word = lane_word[l];
        add_cnt  = 4'(l + 1);
      end
    end
    if (!hit_any)
      for (int l = 0; l < NUM_LANES; l++) add_cnt = add_cnt + {3'b000, ~lane_ovf[l]};
  end

  assign att_sum = {1'b0, attempts_q} + AW'(add_cnt);
  assign att_nxt = att_sum[CNT_W] ? '1 : att_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    if (bus.abort) state_nxt = IDLE;
    else begin
      case (state)
        RUN: begin
          if (hit_any)                 state_nxt = FOUND;
          else if (!all_vld || base_ovf) state_nxt = DONE;
        end
        default: if (bus.start) state_nxt = start_ok ? RUN : DONE;
      endcase
    end
    bus.busy       = (state == RUN);
    bus.found      = (state == FOUND);
    bus.exhausted  = (state == DONE);
    bus.found_word = found_word_q;
    bus.attempts   = attempts_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits       <= '0;
      tgt_q        <= '0;
      len_q        <= '0;
      found_word_q <= '0;
      attempts_q   <= '0;
    end else if (!bus.abort) begin
      if (state != RUN) begin
        if (bus.start) begin
          digits       <= seed_dig;
          tgt_q        <= tgt_m;
          len_q        <= bus.target_len;
          found_word_q <= '0;
          attempts_q   <= '0;
        end
      end else begin
        attempts_q <= att_nxt;
        if (hit_any) found_word_q <= hit_word;
        else         digits       <= base_nxt;
      end
    end
  end
endmodule

// File: tb/tb_bf_search_ctrl.sv
// Directed bench for bf_search_ctrl with MAX_LEN=4, NUM_LANES=4.
module tb_bf_search_ctrl;
  import bf_pkg::*;
  localparam int MAX_LEN = 4, NUM_LANES = 4, CNT_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bf_search_ctrl_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();
  bf_search_ctrl #(.MAX_LEN(MAX_LEN), .NUM_LANES(NUM_LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int n;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [31:0] t, input logic [2:0] len);
    bus.target     = t;
    bus.target_len = len;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
  endtask

  // Cycles spent in RUN after the start edge; bounded so a stuck DUT still reaches the summary
  task automatic run_to_end(output int cyc);
    cyc = 0;
    while (!(bus.found || bus.exhausted) && cyc < 400) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.target = '0; bus.target_len = '0;
`ifdef BF_SEED_EN
    bus.seed = '0;
`endif
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_found", bus.found, 0);
    chk("rst_exh", bus.exhausted, 0);
    chk("rst_word", bus.found_word, 0);
    chk("rst_att", bus.attempts, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // "c": lane 2 of the first compare cycle
    go(32'h63, 3'd1);
    chk("c_busy", bus.busy, 1);
    run_to_end(n);
    chk("c_cyc", n, 1);
    chk("c_found", bus.found, 1);
    chk("c_word", bus.found_word, 32'h63);
    chk("c_att", bus.attempts, 3);

    // "ba" = index 26: base 24, lane 2, seventh RUN cycle; start from FOUND clears flag
    go(32'h6261, 3'd2);
    chk("ba_flagclr", bus.found, 0);
    run_to_end(n);
    chk("ba_cyc", n, 7);
    chk("ba_found", bus.found, 1);
    chk("ba_word", bus.found_word, 32'h6261);
    chk("ba_att", bus.attempts, 27);

    // "A" never matches: 6 full cycles + 2 valid lanes
    go(32'h41, 3'd1);
    run_to_end(n);
    chk("A_cyc", n, 7);
    chk("A_exh", bus.exhausted, 1);
    chk("A_found", bus.found, 0);
    chk("A_att", bus.attempts, 26);

    // zero length: straight to DONE
    go(32'h63, 3'd0);
    chk("len0_exh", bus.exhausted, 1);
    chk("len0_busy", bus.busy, 0);
    chk("len0_att", bus.attempts, 0);

    // start in RUN ignored, abort after 3 RUN cycles holds attempts
    go(32'h7a7a, 3'd2);
    tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_exh", bus.exhausted, 0);
    chk("abort_att", bus.attempts, 12);

    // start+abort together: abort wins
    bus.start = 1'b1; bus.abort = 1'b1;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("sa_busy", bus.busy, 0);
    chk("sa_att", bus.attempts, 12);

    // restart "c" with junk in dead target bytes
    go(32'h7a7a7a63, 3'd1);
    run_to_end(n);
    chk("re_found", bus.found, 1);
    chk("re_word", bus.found_word, 32'h63);
    chk("re_att", bus.attempts, 3);

    // reset mid-RUN
    go(32'h7a7a, 3'd2);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mr_busy", bus.busy, 0);
    chk("mr_att", bus.attempts, 0);
    chk("mr_word", bus.found_word, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // "zz" = index 675: base 672 (169th cycle), lane 3
    go(32'h7a7a, 3'd2);
    run_to_end(n);
    chk("zz_cyc", n, 169);
    chk("zz_found", bus.found, 1);
    chk("zz_word", bus.found_word, 32'h7a7a);
    chk("zz_att", bus.attempts, 676);

    // length beyond MAX_LEN
    go(32'h63, 3'd5);
    chk("len5_exh", bus.exhausted, 1);
    chk("len5_att", bus.attempts, 0);

`ifdef BF_SEED_EN
    bus.seed = 20'd25;
    go(32'h7a, 3'd1);
    run_to_end(n);
    chk("seed_found", bus.found, 1);
    chk("seed_att", bus.attempts, 1);
    bus.seed = 20'd26;
    go(32'h7a, 3'd1);
    chk("seedbad_exh", bus.exhausted, 1);
    chk("seedbad_att", bus.attempts, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
